// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit with eight operations and an accumulate mode.
// Has a one-deep valid/ready output stage and a modulo-2^CNT_W transfer counter.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             F_all,
  output logic             F_any,
  output logic [CNT_W-1:0] count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic [0:0]       state_r;
  logic [0:0]       state_next_s;
  logic [WIDTH-1:0] f_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] operand_b_s;
  logic [WIDTH-1:0] result_s;
  logic             accept_s;
  logic             xfer_s;
  logic             in_ready_s;

  // The output slot frees up in the same cycle the consumer takes it; this is the
  // only combinational path through the block (out_ready -> in_ready).
  assign in_ready_s  = ~rst & ((state_r == ST_EMPTY) | out_ready);
  assign accept_s    = in_valid & in_ready_s;
  assign xfer_s      = (state_r == ST_FULL) & out_ready;
  assign operand_b_s = acc ? acc_r : Y;

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == ST_FULL);
  assign F         = f_r;
  assign F_all     = &f_r;
  assign F_any     = |f_r;
  assign count     = count_r;

  // Operation decode
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (op)
      OP_AND:  result_s = X & operand_b_s;
      OP_OR:   result_s = X | operand_b_s;
      OP_XOR:  result_s = X ^ operand_b_s;
      OP_NAND: result_s = ~(X & operand_b_s);
      OP_NOR:  result_s = ~(X | operand_b_s);
      OP_XNOR: result_s = ~(X ^ operand_b_s);
      OP_NOT:  result_s = ~X;
      OP_PASS: result_s = X;
      default: result_s = X;
    endcase
  end

  // Output-slot occupancy; a simultaneous take and refill keeps the slot full
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_s && !accept_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // State, result, accumulator and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      f_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b1}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        f_r   <= result_s;
        acc_r <= result_s;
      end
      if (xfer_s) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed scenarios plus randomized traffic
// compared against a behavioural model built from the operation table and handshake rules.
module tb_logic_gate_unit;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic          acc;
  logic [W-1:0]  X;
  logic [W-1:0]  Y;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  F;
  logic          F_all;
  logic          F_any;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  // model state
  bit            m_valid;
  logic [W-1:0]  m_f;
  logic [W-1:0]  m_acc;
  int            m_count;

  logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc(acc), .X(X), .Y(Y),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .F_all(F_all), .F_any(F_any), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  function automatic bit model_ready();
    return !rst && (!m_valid || out_ready);
  endfunction

  // Advance one clock edge and update the model from the inputs held across it.
  task automatic step();
    bit           take;
    bit           xf;
    logic [W-1:0] r;
    take = in_valid && model_ready();
    xf   = m_valid && out_ready;
    r    = ref_op(op, X, acc ? m_acc : Y);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_f = '0; m_acc = '1; m_count = 0;
    end else begin
      if (xf) m_count = (m_count + 1) % (1 << CW);
      if (take) begin
        m_f = r; m_acc = r; m_valid = 1;
      end else if (xf) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; X = 8'hFF; Y = 8'hFF; op = 3'd7; acc = 1'b0; out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (F !== 8'h00) begin bad++; $display("FAIL reset_F got=%h exp=00", F); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (F_all !== 1'b0 || F_any !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", F_all, F_any); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
  endtask

  task automatic test_op_sweep();
    logic [W-1:0] expv [8];
    expv = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
    apply_reset();
    out_ready = 1'b1; acc = 1'b0; X = 8'hF0; Y = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i); in_valid = 1'b1;
      step();
      total++; if (F !== expv[i] || out_valid !== 1'b1) begin
        bad++; $display("FAIL op_sweep op=%0d got=%h/%b exp=%h/1", i, F, out_valid, expv[i]);
      end
    end
    in_valid = 1'b0;
    step();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL op_sweep_count got=%0d exp=8", count); end
  endtask

  task automatic test_accumulate();
    logic [W-1:0] xs [3];
    logic [W-1:0] fs [3];
    xs = '{8'hF0, 8'h3C, 8'h0F};
    fs = '{8'hF0, 8'h30, 8'h00};
    apply_reset();
    acc = 1'b1; op = 3'd0; out_ready = 1'b1; Y = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      X = xs[i]; in_valid = 1'b1;
      step();
      total++; if (F !== fs[i] || F_all !== 1'b0) begin
        bad++; $display("FAIL accumulate step=%0d got=%h all=%b exp=%h all=0", i, F, F_all, fs[i]);
      end
    end
    total++; if (F_any !== 1'b0) begin bad++; $display("FAIL accumulate_any got=%b exp=0", F_any); end
    in_valid = 1'b0; acc = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; X = 8'hFF; op = 3'd7; acc = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || F !== 8'hFF) begin
      bad++; $display("FAIL bp_load got v=%b r=%b F=%h exp v=1 r=0 F=ff", out_valid, in_ready, F);
    end
    X = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (F !== 8'hFF || in_ready !== 1'b0 || count !== 4'd0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got F=%h r=%b cnt=%0d exp F=ff r=0 cnt=0", i, F, in_ready, count);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_path got=%b exp=1", in_ready); end
    step();
    total++; if (count !== 4'd1 || F !== 8'h00 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release got cnt=%0d F=%h v=%b exp cnt=1 F=00 v=1", count, F, out_valid);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    apply_reset();
    in_valid = 1'b1; out_ready = 1'b1; op = 3'd7; acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      X = 8'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, in_ready); end
      step();
      total++; if (F !== 8'(i) || out_valid !== 1'b1) begin
        bad++; $display("FAIL stream_F i=%0d got=%h exp=%h", i, F, 8'(i));
      end
    end
    in_valid = 1'b0;
    step();
    total++; if (count !== 4'd10) begin bad++; $display("FAIL stream_count got=%0d exp=10", count); end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    in_valid = 1'b1; out_ready = 1'b1; op = 3'd7; acc = 1'b0;
    // first edge only loads; each later edge completes one transfer
    for (int n = 0; n <= 17; n++) begin
      X = 8'($urandom);
      step();
      if (n == 15 || n == 16 || n == 17) begin
        total++; if (count !== 4'(n % 16)) begin
          bad++; $display("FAIL wrap xfers=%0d got=%0d exp=%0d", n, count, n % 16);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    acc = 1'b0; op = 3'd7; out_ready = 1'b1; in_valid = 1'b1;
    X = 8'h11; step();
    X = 8'hAA; step();
    out_ready = 1'b0; in_valid = 1'b0; step();
    total++; if (F !== 8'hAA || out_valid !== 1'b1 || count !== 4'd1) begin
      bad++; $display("FAIL mid_setup got F=%h v=%b cnt=%0d exp F=aa v=1 cnt=1", F, out_valid, count);
    end
    rst = 1'b1; in_valid = 1'b1; X = 8'h77;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || F !== 8'h00 || count !== 4'd0) begin
      bad++; $display("FAIL mid_reset got v=%b F=%h cnt=%0d exp v=0 F=00 cnt=0", out_valid, F, count);
    end
    rst = 1'b0; acc = 1'b1; op = 3'd0; X = 8'h5A; out_ready = 1'b1; in_valid = 1'b1;
    step();
    total++; if (F !== 8'h5A) begin bad++; $display("FAIL mid_acc_restore got=%h exp=5a", F); end
    in_valid = 1'b0; acc = 1'b0;
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom);
      acc       = 1'($urandom);
      X         = 8'($urandom);
      Y         = 8'($urandom);
      #1;
      total++; if (in_ready !== model_ready()) begin
        bad++; $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, in_ready, model_ready());
      end
      step();
      total++; if (out_valid !== m_valid || F !== m_f || count !== 4'(m_count)
                   || F_all !== (m_f == 8'hFF) || F_any !== (m_f != 8'h00)) begin
        bad++; $display("FAIL rand_out i=%0d got v=%b F=%h cnt=%0d all=%b any=%b exp v=%b F=%h cnt=%0d",
                        i, out_valid, F, count, F_all, F_any, m_valid, m_f, m_count);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; acc = 1'b0; X = '0; Y = '0;
    m_valid = 0; m_f = '0; m_acc = '1; m_count = 0;
    test_reset();
    test_op_sweep();
    test_accumulate();
    test_backpressure();
    test_streaming();
    test_counter_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
Parametrised, registered bitwise logic unit. It is the successor to the single-bit two-input AND gate primitive. It is generalised to WIDTH bits, eight selectable operations, an optional accumulate mode, and a one-deep valid/ready output stage with a transfer counter. It sits between a producer and a consumer that both use valid/ready, as a reusable course datapath element.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
CNT_W, 16, width of the transfer counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer offers X/Y/op/acc this cycle
in_ready  output  1  unit can accept input this cycle
op  input  3  operation select (see Behaviour)
acc  input  1  1 = replace Y with internal accumulator
X  input  WIDTH  operand A
Y  input  WIDTH  operand B
out_valid  output  1  F holds an unconsumed result
out_ready  input  1  consumer accepts F this cycle
F  output  WIDTH  registered result
F_all  output  1  reduction AND of F
F_any  output  1  reduction OR of F
count  output  CNT_W  number of completed output transfers, modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all state updates on the rising clk edge.
- Reset values: out_valid=0, F=0, count=0, accumulator ACC=all ones. F_all and F_any follow from F, so both are 0 after reset.
- While rst=1: in_ready=0 and no transfer occurs.
- Operations, with B = acc ? ACC : Y:
  - 0 AND: X&B
  - 1 OR: X|B
  - 2 XOR: X^B
  - 3 NAND: ~(X&B)
  - 4 NOR: ~(X|B)
  - 5 XNOR: ~(X^B)
  - 6 NOT: ~X (B ignored)
  - 7 PASS: X (B ignored)
- Input accept: accept = in_valid & in_ready.
- Output transfer: xfer = out_valid & out_ready.
- Handshake: in_ready = ~rst & (~out_valid | out_ready). This is combinational, and back-to-back throughput is 1 result per cycle.
- State machine:
  - EMPTY (out_valid=0): accept -> FULL.
  - FULL (out_valid=1), no xfer: hold; F stable, in_ready=0.
  - FULL, xfer with no accept: -> EMPTY.
  - FULL, simultaneous xfer and accept: stay FULL; F loads the new result in the same edge.
- Latency: result appears on F with out_valid=1 on the cycle after accept.
- ACC is loaded with the computed result on every accept, in either acc mode and for any op. ACC is never changed by xfer alone.
- count increments by 1 on each xfer and wraps from 2^CNT_W-1 to 0.
- Inputs are ignored when in_valid=0. X/Y/op/acc may change freely when not accepted.
- F_all = &F and F_any = |F, combinational from the F register.
- Reset mid-operation: a pending result is discarded (out_valid->0, F->0) and count and ACC return to their reset values. Inputs offered while rst=1 are dropped.
- No combinational path from in_valid or operands to outputs. The only combinational path is out_ready -> in_ready.

Test Plan:
- Op sweep (WIDTH=8, out_ready=1, acc=0, X=8'hF0, Y=8'h3C, op 0..7) -> F one cycle later:
  - ops 0-5: 30, FC, CC, CF, 03, 33
  - ops 6-7: 0F, F0
  - count ends at 8.
- Accumulate after reset (acc=1, op=AND): X=F0 then 3C then 0F -> F=F0, 30, 00.
  - F_any ends 0; F_all stays 0 throughout.
- Backpressure: out_ready=0, accept X=FF op=PASS -> out_valid=1, in_ready=0.
  - Offered X=00 is not accepted for 5 cycles; F=FF held.
  - Raise out_ready -> count=1 and X=00 accepted in the same cycle; F=00 next cycle.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with X incrementing from 0, op=PASS -> F follows X delayed by 1, in_ready stays 1, count=10.
- Counter wrap (CNT_W=4): 17 transfers -> count reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
- Reset mid-operation: stalled with F=AA and out_valid=1, assert rst for 1 cycle.
  - Result: out_valid=0, F=00, count=0, in_ready=0 during rst.
  - Next accept with acc=1, op=AND, X=5A -> F=5A, confirming ACC was restored to FF.
